// File: rtl/crossy_pkg.sv
// Shared types and constants for the loot arbiter slice.
// Holds the per-slot state encoding, loot value width, and the LFSR seed/mask
// plus the small helpers used when the LFSR build option is enabled.
package crossy_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACTIVE = 2'd2,
      GRANT  = 2'd3
   } slot_state_t;

   localparam int unsigned LOOT_VAL_W = 2;
   localparam int unsigned LFSR_W     = 16;
   localparam int unsigned JITTER_W   = 6;

   localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
   localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

   // One Galois step: shift right, fold the mask in when a 1 falls out.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
      return cur[0] ? ((cur >> 1) ^ LFSR_MASK) : (cur >> 1);
   endfunction

   // Loot value is never 0, so a zero draw maps to the smallest item.
   function automatic logic [LOOT_VAL_W-1:0] lfsr_loot_value(input logic [LOOT_VAL_W-1:0] bits);
      return (bits == '0) ? LOOT_VAL_W'(1) : bits;
   endfunction

endpackage

// File: rtl/loot_arbiter_if.sv
// Bundle between the loot arbiter and its neighbours (round control, hitboxes, players).
//   SpawnEnable      round active
//   P1Touch/P2Touch  per-slot hitbox overlap for each player
//   P1Ack/P2Ack      player Collected acknowledge
//   P1Collect/P2Collect  single-frame value offered to each player
//   SlotVisible      per-slot draw enable
//   SlotValue        per-slot value, LOOT_VAL_W bits each
// master = environment side, slave = arbiter side.
interface loot_arbiter_if
   import crossy_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 4
) ();

   logic                             SpawnEnable;
   logic [NUM_SLOTS-1:0]             P1Touch;
   logic [NUM_SLOTS-1:0]             P2Touch;
   logic                             P1Ack;
   logic                             P2Ack;
   logic [LOOT_VAL_W-1:0]            P1Collect;
   logic [LOOT_VAL_W-1:0]            P2Collect;
   logic [NUM_SLOTS-1:0]             SlotVisible;
   logic [LOOT_VAL_W*NUM_SLOTS-1:0]  SlotValue;

   modport master (
      output SpawnEnable, P1Touch, P2Touch, P1Ack, P2Ack,
      input  P1Collect, P2Collect, SlotVisible, SlotValue
   );

   modport slave (
      input  SpawnEnable, P1Touch, P2Touch, P1Ack, P2Ack,
      output P1Collect, P2Collect, SlotVisible, SlotValue
   );

endinterface

// File: rtl/loot_slot.sv
// One loot slot: respawn FSM, countdown timer and latched value.
//   clk, rst_n    frame clock, async active-low reset
//   spawn_en_i    round active; low forces IDLE and clears the slot
//   grant_i       slot handed to a player this frame (only honoured in ACTIVE)
//   ack_i         owner's Collected ack, meaningful only in the ack window
//   reload_i      hidden-time after a confirmed pickup
//   value_i       value latched when the slot appears
//   state_o       current slot state
//   visible_o     slot drawn (ACTIVE or GRANT)
//   value_o       latched value (0 while not holding an item)
//   ack_window_c  second GRANT frame: the edge that samples the owner's ack
module loot_slot
   import crossy_pkg::*;
#(
   parameter int unsigned TIMER_W   = 9,
   parameter int unsigned INIT_LOAD = 60
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  spawn_en_i,
   input  logic                  grant_i,
   input  logic                  ack_i,
   input  logic [TIMER_W-1:0]    reload_i,
   input  logic [LOOT_VAL_W-1:0] value_i,
   output slot_state_t           state_o,
   output logic                  visible_o,
   output logic [LOOT_VAL_W-1:0] value_o,
   output logic                  ack_window_c
);

   slot_state_t           state_q, state_d;
   logic [TIMER_W-1:0]    timer_q, timer_d;
   logic                  phase_q, phase_d;
   logic [LOOT_VAL_W-1:0] value_q, value_d;
   logic                  visible_q, visible_d;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         phase_q   <= 1'b0;
         value_q   <= '0;
         visible_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         phase_q   <= phase_d;
         value_q   <= value_d;
         visible_q <= visible_d;
      end
   end

   // Next state: the loaded timer value is the number of frames spent in WAIT
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      phase_d = phase_q;
      value_d = value_q;

      if (!spawn_en_i) begin
         state_d = IDLE;
         timer_d = '0;
         phase_d = 1'b0;
         value_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = WAIT;
               timer_d = TIMER_W'(INIT_LOAD);
            end
            WAIT: begin
               // <= 1 also covers a zero load, so the counter never wraps
               if (timer_q <= TIMER_W'(1)) begin
                  state_d = ACTIVE;
                  timer_d = '0;
                  value_d = value_i;
               end else begin
                  timer_d = timer_q - TIMER_W'(1);
               end
            end
            ACTIVE: begin
               if (grant_i) begin
                  state_d = GRANT;
                  phase_d = 1'b0;
               end
            end
            GRANT: begin
               if (!phase_q) begin
                  phase_d = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  if (ack_i) begin
                     state_d = WAIT;
                     timer_d = reload_i;
                     value_d = '0;
                  end else begin
                     state_d = ACTIVE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      visible_d = (state_d == ACTIVE) || (state_d == GRANT);
   end

   assign state_o      = state_q;
   assign visible_o    = visible_q;
   assign value_o      = value_q;
   assign ack_window_c = (state_q == GRANT) && phase_q;

endmodule

// File: rtl/loot_arbiter.sv
// Loot arbiter: owns NUM_SLOTS loot slots, arbitrates P1/P2 touches and runs the
// Collect/Collected handshake with each player.
//   FrameClk  frame clock
//   Reset_n   async active-low reset
//   bus       loot_arbiter_if.slave (round enable, touches, acks, collect values,
//             slot visibility and values)
// Build option LOOT_LFSR_EN: randomised loot value and respawn jitter from a
// 16-bit Galois LFSR. Without it every item is worth 1 and the respawn time is fixed.
module loot_arbiter
   import crossy_pkg::*;
#(
   parameter int unsigned NUM_SLOTS      = 4,
   parameter int unsigned TIMER_W        = 9,
   parameter int unsigned RESPAWN_FRAMES = 180,
   parameter int unsigned INIT_FRAMES    = 60,
   parameter int unsigned STAGGER        = 16
) (
   input  logic          FrameClk,
   input  logic          Reset_n,
   loot_arbiter_if.slave bus
);

   localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
`ifdef LOOT_LFSR_EN
   localparam int unsigned JITTER_MAX = (1 << JITTER_W) - 1;
`else
   localparam int unsigned JITTER_MAX = 0;
`endif
   localparam int unsigned RELOAD_MAX  = RESPAWN_FRAMES + JITTER_MAX;
   localparam int unsigned INIT_MAX    = INIT_FRAMES + STAGGER * (NUM_SLOTS - 1);
   localparam int unsigned TIMER_LIMIT = (1 << TIMER_W) - 1;

   // Every timer load must fit the countdown register
   if (RELOAD_MAX > TIMER_LIMIT) begin : g_reload_chk
      $error("loot_arbiter: respawn reload does not fit TIMER_W");
   end
   if (INIT_MAX > TIMER_LIMIT) begin : g_init_chk
      $error("loot_arbiter: initial spawn delay does not fit TIMER_W");
   end

   logic                  spawn_en;
   slot_state_t           slot_state   [NUM_SLOTS];
   logic [LOOT_VAL_W-1:0] slot_value   [NUM_SLOTS];
   logic [NUM_SLOTS-1:0]  slot_visible;
   logic [NUM_SLOTS-1:0]  slot_window;
   logic [NUM_SLOTS-1:0]  slot_grant;
   logic [NUM_SLOTS-1:0]  slot_ack;
   logic [TIMER_W-1:0]    reload;
   logic [LOOT_VAL_W-1:0] new_value;

   logic                  p1_cand_vld, p2_cand_vld;
   logic [IDX_W-1:0]      p1_cand, p2_cand;
   logic                  p1_elig, p2_elig, same_cand;
   logic                  p1_win, p2_win;

   logic                  prio_q, prio_d;
   logic                  p1_pend_q, p1_pend_d, p2_pend_q, p2_pend_d;
   logic [IDX_W-1:0]      p1_slot_q, p1_slot_d, p2_slot_q, p2_slot_d;
   logic [LOOT_VAL_W-1:0] p1_collect_q, p1_collect_d, p2_collect_q, p2_collect_d;

   assign spawn_en = bus.SpawnEnable;

`ifdef LOOT_LFSR_EN
   logic [LFSR_W-1:0] lfsr_q, lfsr_d;

   // LFSR free-runs during a round; value and jitter are drawn from its low bits
   always_comb begin
      lfsr_d = lfsr_q;
      if (spawn_en) lfsr_d = lfsr_next(lfsr_q);
   end

   always_ff @(posedge FrameClk or negedge Reset_n) begin
      if (!Reset_n) lfsr_q <= LFSR_SEED;
      else          lfsr_q <= lfsr_d;
   end

   assign new_value = lfsr_loot_value(lfsr_q[1:0]);
   assign reload    = TIMER_W'(RESPAWN_FRAMES) + TIMER_W'(lfsr_q[7:2]);
`else
   assign new_value = LOOT_VAL_W'(1);
   assign reload    = TIMER_W'(RESPAWN_FRAMES);
`endif

   // Candidate per player: lowest-index ACTIVE slot it touches
   always_comb begin
      p1_cand_vld = 1'b0;
      p1_cand     = '0;
      p2_cand_vld = 1'b0;
      p2_cand     = '0;
      for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
         if (slot_state[i] == ACTIVE && bus.P1Touch[i]) begin
            p1_cand_vld = 1'b1;
            p1_cand     = IDX_W'(i);
         end
         if (slot_state[i] == ACTIVE && bus.P2Touch[i]) begin
            p2_cand_vld = 1'b1;
            p2_cand     = IDX_W'(i);
         end
      end
   end

   // A player with a grant in flight sits out; ties go to the Prio player
   always_comb begin
      p1_elig   = p1_cand_vld && !p1_pend_q;
      p2_elig   = p2_cand_vld && !p2_pend_q;
      same_cand = p1_elig && p2_elig && (p1_cand == p2_cand);
      p1_win    = p1_elig && !(same_cand && prio_q);
      p2_win    = p2_elig && !(same_cand && !prio_q);
   end

   // Per-slot grant and the owning player's ack
   always_comb begin
      slot_grant = '0;
      slot_ack   = '0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
         slot_grant[i] = (p1_win && p1_cand == IDX_W'(i)) ||
                         (p2_win && p2_cand == IDX_W'(i));
         slot_ack[i]   = (p1_pend_q && p1_slot_q == IDX_W'(i) && bus.P1Ack) ||
                         (p2_pend_q && p2_slot_q == IDX_W'(i) && bus.P2Ack);
      end
   end

   // Prio, pending-grant tracking and the single-frame Collect pulses
   always_comb begin
      prio_d       = prio_q;
      p1_pend_d    = p1_pend_q;
      p1_slot_d    = p1_slot_q;
      p2_pend_d    = p2_pend_q;
      p2_slot_d    = p2_slot_q;
      p1_collect_d = '0;
      p2_collect_d = '0;

      if (!spawn_en) begin
         prio_d    = 1'b0;
         p1_pend_d = 1'b0;
         p1_slot_d = '0;
         p2_pend_d = 1'b0;
         p2_slot_d = '0;
      end else begin
         if (same_cand) prio_d = ~prio_q;

         // The owned slot leaves GRANT on its ack-window edge either way
         if (p1_pend_q && slot_window[p1_slot_q]) p1_pend_d = 1'b0;
         if (p2_pend_q && slot_window[p2_slot_q]) p2_pend_d = 1'b0;

         if (p1_win) begin
            p1_pend_d    = 1'b1;
            p1_slot_d    = p1_cand;
            p1_collect_d = slot_value[p1_cand];
         end
         if (p2_win) begin
            p2_pend_d    = 1'b1;
            p2_slot_d    = p2_cand;
            p2_collect_d = slot_value[p2_cand];
         end
      end
   end

   always_ff @(posedge FrameClk or negedge Reset_n) begin
      if (!Reset_n) begin
         prio_q       <= 1'b0;
         p1_pend_q    <= 1'b0;
         p1_slot_q    <= '0;
         p2_pend_q    <= 1'b0;
         p2_slot_q    <= '0;
         p1_collect_q <= '0;
         p2_collect_q <= '0;
      end else begin
         prio_q       <= prio_d;
         p1_pend_q    <= p1_pend_d;
         p1_slot_q    <= p1_slot_d;
         p2_pend_q    <= p2_pend_d;
         p2_slot_q    <= p2_slot_d;
         p1_collect_q <= p1_collect_d;
         p2_collect_q <= p2_collect_d;
      end
   end

   // Slot instances, each with its own staggered first appearance
   for (genvar g = 0; g < int'(NUM_SLOTS); g++) begin : g_slot
      loot_slot #(
         .TIMER_W   (TIMER_W),
         .INIT_LOAD (INIT_FRAMES + STAGGER * g)
      ) u_slot (
         .clk          (FrameClk),
         .rst_n        (Reset_n),
         .spawn_en_i   (spawn_en),
         .grant_i      (slot_grant[g]),
         .ack_i        (slot_ack[g]),
         .reload_i     (reload),
         .value_i      (new_value),
         .state_o      (slot_state[g]),
         .visible_o    (slot_visible[g]),
         .value_o      (slot_value[g]),
         .ack_window_c (slot_window[g])
      );

      assign bus.SlotValue[g*LOOT_VAL_W +: LOOT_VAL_W] = slot_value[g];
   end

   assign bus.SlotVisible = slot_visible;
   assign bus.P1Collect   = p1_collect_q;
   assign bus.P2Collect   = p2_collect_q;

endmodule
